customer_deposit: RTL and testbench
===================================

# customer_deposit

Customer-side front end of the vending machine and the write side of the machine accumulator. It accepts coins, holds customer credit, executes purchases and returns change. Each sale price is added into `machineAcc`, which is the value the owner-retrieve block reads and empties in owner mode.

## Interface
Parameters:
- `CREDIT_W`, 5: credit, price and change width; maximum credit is 2^CREDIT_W−1 = 31.
- `ACC_W`, 7: machine accumulator width; saturates at 127.

Ports:
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `mode`  in  1  1 = customer mode (deposits and sales enabled), 0 = owner mode.
- `coinValid`  in  1  one-cycle strobe, coin present.
- `coinCode`  in  2  coin value code: 00 = 1, 01 = 2, 10 = 5, 11 = 10.
- `buy`  in  1  one-cycle purchase request.
- `price`  in  CREDIT_W  item price, sampled only with `buy`.
- `cancel`  in  1  one-cycle refund request.
- `accClear`  in  1  one-cycle strobe from the owner-retrieve block; zeroes the accumulator.
- `changeAck`  in  1  change dispenser has taken `changeAmount`.
- `credit`  out  CREDIT_W  current customer credit.
- `machineAcc`  out  ACC_W  accumulated sales total.
- `vend`  out  1  one-cycle pulse, item released.
- `coinReject`  out  1  one-cycle pulse, the offered coin was returned.
- `changeValid`  out  1  change pending, held until acknowledged.
- `changeAmount`  out  CREDIT_W  change value, stable while `changeValid` is high.
- `redLight`  out  1  error level: failed buy or accumulator saturated.

## Operation
- All outputs are registered. Reset sets every output and the state to 0 / IDLE.
- States:
  - IDLE: credit is 0. An accepted coin loads its value and moves to COLLECT.
  - COLLECT: coins accumulate into credit.
  - CHANGE: `changeValid` = 1 until `changeAck`, then IDLE.
- A coin is accepted only when `mode`=1, the state is IDLE or COLLECT, no `buy` or `cancel` arrives that cycle, and credit + value ≤ 31.
  - Any other coin produces a `coinReject` pulse. Credit is unchanged.
- `buy` in COLLECT with `price`≠0 and credit ≥ price: this is a sale, all at the same edge:
  - `vend` pulses.
  - machineAcc ← min(machineAcc + price, 127).
  - changeAmount ← credit − price.
  - credit ← 0.
  - Next state is CHANGE if the remainder is >0, else IDLE.
- `buy` with insufficient credit or `price`=0: no sale. `redLight` ← 1 and credit is kept.
- `redLight` clears on the next accepted coin or on `cancel`, unless the accumulator is saturated.
  - A saturated accumulator holds `redLight` at 1 until `accClear`.
- `cancel` in COLLECT: changeAmount ← credit, credit ← 0, next state CHANGE.
- `buy` and `cancel` in IDLE or CHANGE are ignored.
- Priority in one cycle: `cancel` > `buy` > coin.
- `mode` 1→0 while in COLLECT is treated as `cancel`.
- `accClear` zeroes `machineAcc` in any state.
  - If it coincides with a sale, the result is `machineAcc` = price (clear first, then add).

## Timing
- Coin sampled at edge k; `credit` is updated and visible after edge k. Latency is 1 cycle.
- `buy` or `cancel` at edge k: `vend`, `machineAcc`, `changeAmount` and `changeValid` all update at edge k. `vend` is high for exactly cycle k..k+1.
- `coinReject` is a one-cycle pulse that follows the rejected strobe.
- `changeAck` sampled at edge j while in CHANGE: `changeValid` drops after edge j and the block is in IDLE. A coin at edge j+1 is accepted.
- `changeAck` while `changeValid`=0 is ignored.
- `rst` asserted mid-sale or mid-change takes effect immediately.
  - Credit, pending change and `machineAcc` are lost; all outputs go to 0.

## Structure
- Shared package `vm_pkg`:
  - coin code constants (COIN_1, COIN_2, COIN_5, COIN_10);
  - state encoding (IDLE, COLLECT, CHANGE);
  - default widths `CREDIT_W` and `ACC_W`, shared with the owner-retrieve block.
- One sub-module, `coin_decoder`: combinational, `coinCode` → CREDIT_W value.
- The FSM, credit register, accumulator and output registers live in `customer_deposit`.

## Test plan
- Reset, then coins 5,5,2 → credit 12. `buy` with price 10 → `vend` pulse, machineAcc 10, changeValid with changeAmount 2. `changeAck` → IDLE, credit 0.
- Credit 3, `buy` with price 7 → no vend, redLight 1, credit 3. Coin 5 → credit 8, redLight 0.
- Credit 25, coin 10 → coinReject, credit 25. Coin 5 → credit 30.
- Same cycle: coinValid (10) + buy (price 4) with credit 4 → vend, coinReject, changeValid 0, state IDLE.
- machineAcc 120, sale with price 10 → machineAcc 127, redLight 1. `accClear` → machineAcc 0, redLight 0.
- Credit 6, mode drops to 0 → changeValid with changeAmount 6. Coin in owner mode → coinReject. `rst` during CHANGE → all outputs 0.

Source files
------------

// File: rtl/vm_pkg.sv
// Shared vending-machine definitions: coin codes, FSM states, default widths.
// Used by the customer deposit path and the owner-retrieve block.
package vm_pkg;

    localparam int CREDIT_W = 5;
    localparam int ACC_W    = 7;

    localparam logic [1:0] COIN_1  = 2'b00;
    localparam logic [1:0] COIN_2  = 2'b01;
    localparam logic [1:0] COIN_5  = 2'b10;
    localparam logic [1:0] COIN_10 = 2'b11;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        CHANGE  = 2'd2
    } state_t;

endpackage

// File: rtl/coin_decoder.sv
// Combinational coin code to coin value translation.
// Purely a lookup; the caller decides whether the coin is accepted.
module coin_decoder #(
    parameter int CREDIT_W = vm_pkg::CREDIT_W
) (
    input  logic [1:0]          coinCode,
    output logic [CREDIT_W-1:0] value
);
    import vm_pkg::*;

    always_comb begin
        value = '0;
        unique case (coinCode)
            COIN_1:  value = CREDIT_W'(1);
            COIN_2:  value = CREDIT_W'(2);
            COIN_5:  value = CREDIT_W'(5);
            COIN_10: value = CREDIT_W'(10);
        endcase
    end

endmodule

// File: rtl/customer_deposit.sv
// Customer front end: coin intake, credit, purchases, change and the
// write side of the machine sales accumulator.
module customer_deposit #(
    parameter int CREDIT_W = vm_pkg::CREDIT_W,
    parameter int ACC_W    = vm_pkg::ACC_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                mode,
    input  logic                coinValid,
    input  logic [1:0]          coinCode,
    input  logic                buy,
    input  logic [CREDIT_W-1:0] price,
    input  logic                cancel,
    input  logic                accClear,
    input  logic                changeAck,
    output logic [CREDIT_W-1:0] credit,
    output logic [ACC_W-1:0]    machineAcc,
    output logic                vend,
    output logic                coinReject,
    output logic                changeValid,
    output logic [CREDIT_W-1:0] changeAmount,
    output logic                redLight
);
    import vm_pkg::*;

    localparam logic [CREDIT_W:0] CREDIT_MAX = {1'b0, {CREDIT_W{1'b1}}};
    localparam logic [ACC_W:0]    ACC_MAX    = {1'b0, {ACC_W{1'b1}}};

    state_t              r_state, w_state;
    logic [CREDIT_W-1:0] r_credit, w_credit;
    logic [ACC_W-1:0]    r_acc, w_acc;
    logic                r_vend, w_vend;
    logic                r_coinReject, w_coinReject;
    logic                r_changeValid, w_changeValid;
    logic [CREDIT_W-1:0] r_changeAmount, w_changeAmount;
    logic                r_redLight, w_redLight;

    logic [CREDIT_W-1:0] w_coinVal;
    logic [CREDIT_W:0]   w_coinSum;
    logic [CREDIT_W-1:0] w_remain;
    logic [ACC_W-1:0]    w_accBase;
    logic [ACC_W:0]      w_accSum;
    logic                w_collect;
    logic                w_cancel;
    logic                w_buy;
    logic                w_sale;
    logic                w_buyFail;
    logic                w_coinAcc;
    logic                w_accSat;
    logic                w_accWasSat;

    coin_decoder #(
        .CREDIT_W (CREDIT_W)
    ) u_coin_decoder (
        .coinCode (coinCode),
        .value    (w_coinVal)
    );

    // Leaving customer mode with credit held behaves exactly like cancel.
    assign w_collect = (r_state == COLLECT);
    assign w_cancel  = w_collect && (cancel || !mode);
    assign w_buy     = w_collect && buy && !w_cancel;
    assign w_sale    = w_buy && (price != '0) && (r_credit >= price);
    assign w_buyFail = w_buy && !w_sale;

    assign w_coinSum = {1'b0, r_credit} + {1'b0, w_coinVal};
    assign w_coinAcc = coinValid && mode && !buy && !cancel
                     && (r_state == IDLE || w_collect)
                     && (w_coinSum <= CREDIT_MAX);

    assign w_remain  = r_credit - price;

    // Clear is applied before the sale amount is added.
    assign w_accBase = accClear ? '0 : r_acc;
    assign w_accSum  = {1'b0, w_accBase}
                     + {{(ACC_W + 1 - CREDIT_W){1'b0}}, price};
    assign w_accWasSat = (r_acc == ACC_MAX[ACC_W-1:0]);

    always_comb begin
        w_state        = r_state;
        w_credit       = r_credit;
        w_acc          = w_accBase;
        w_vend         = 1'b0;
        w_coinReject   = coinValid && !w_coinAcc;
        w_changeValid  = r_changeValid;
        w_changeAmount = r_changeAmount;

        if (w_sale) begin
            w_acc = (w_accSum > ACC_MAX) ? ACC_MAX[ACC_W-1:0]
                                         : w_accSum[ACC_W-1:0];
        end

        unique case (r_state)
            IDLE: begin
                if (w_coinAcc) begin
                    w_credit = w_coinVal;
                    w_state  = COLLECT;
                end
            end
            COLLECT: begin
                if (w_cancel) begin
                    w_changeAmount = r_credit;
                    w_changeValid  = 1'b1;
                    w_credit       = '0;
                    w_state        = CHANGE;
                end else if (w_sale) begin
                    w_vend         = 1'b1;
                    w_changeAmount = w_remain;
                    w_changeValid  = (w_remain != '0);
                    w_credit       = '0;
                    w_state        = (w_remain != '0) ? CHANGE : IDLE;
                end else if (w_coinAcc) begin
                    w_credit = w_coinSum[CREDIT_W-1:0];
                end
            end
            CHANGE: begin
                if (changeAck) begin
                    w_changeValid  = 1'b0;
                    w_changeAmount = '0;
                    w_state        = IDLE;
                end
            end
            default: begin
                w_state = IDLE;
            end
        endcase

        w_accSat = (w_acc == ACC_MAX[ACC_W-1:0]);

        // Saturation dominates; a clear only releases it once the
        // accumulator has actually been emptied.
        if (w_accSat || w_buyFail) begin
            w_redLight = 1'b1;
        end else if (w_coinAcc || cancel || w_cancel) begin
            w_redLight = 1'b0;
        end else if (accClear && w_accWasSat) begin
            w_redLight = 1'b0;
        end else begin
            w_redLight = r_redLight;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state        <= IDLE;
            r_credit       <= '0;
            r_acc          <= '0;
            r_vend         <= 1'b0;
            r_coinReject   <= 1'b0;
            r_changeValid  <= 1'b0;
            r_changeAmount <= '0;
            r_redLight     <= 1'b0;
        end else begin
            r_state        <= w_state;
            r_credit       <= w_credit;
            r_acc          <= w_acc;
            r_vend         <= w_vend;
            r_coinReject   <= w_coinReject;
            r_changeValid  <= w_changeValid;
            r_changeAmount <= w_changeAmount;
            r_redLight     <= w_redLight;
        end
    end

    assign credit       = r_credit;
    assign machineAcc   = r_acc;
    assign vend         = r_vend;
    assign coinReject   = r_coinReject;
    assign changeValid  = r_changeValid;
    assign changeAmount = r_changeAmount;
    assign redLight     = r_redLight;

endmodule

// File: tb/tb_customer_deposit.sv
// Directed scoreboard bench for customer_deposit: stimulus pushes the
// hand-computed post-edge outputs, a monitor pops and compares them.
module tb_customer_deposit;
    import vm_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       mode = 1'b0;
    logic       coinValid = 1'b0;
    logic [1:0] coinCode = 2'b00;
    logic       buy = 1'b0;
    logic [4:0] price = 5'd0;
    logic       cancel = 1'b0;
    logic       accClear = 1'b0;
    logic       changeAck = 1'b0;

    logic [4:0] credit;
    logic [6:0] machineAcc;
    logic       vend;
    logic       coinReject;
    logic       changeValid;
    logic [4:0] changeAmount;
    logic       redLight;

    typedef struct {
        int         id;
        logic [4:0] cr;
        logic [6:0] acc;
        logic       vend;
        logic       rej;
        logic       cv;
        logic [4:0] ca;
        logic       red;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   n_id  = 0;

    customer_deposit #(
        .CREDIT_W (5),
        .ACC_W    (7)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .mode         (mode),
        .coinValid    (coinValid),
        .coinCode     (coinCode),
        .buy          (buy),
        .price        (price),
        .cancel       (cancel),
        .accClear     (accClear),
        .changeAck    (changeAck),
        .credit       (credit),
        .machineAcc   (machineAcc),
        .vend         (vend),
        .coinReject   (coinReject),
        .changeValid  (changeValid),
        .changeAmount (changeAmount),
        .redLight     (redLight)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int id,
                       input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s vec%0d: got %0d want %0d", nm, id, act, exp);
        end
    endtask

    // Monitor: reset is checked right after its asynchronous rise.
    always @(posedge clk or posedge rst) begin
        exp_t e;
        #1;
        if (q.size() > 0) begin
            e = q.pop_front();
            chk("credit",       e.id, {3'b0, credit},       {3'b0, e.cr});
            chk("machineAcc",   e.id, {1'b0, machineAcc},   {1'b0, e.acc});
            chk("vend",         e.id, {7'b0, vend},         {7'b0, e.vend});
            chk("coinReject",   e.id, {7'b0, coinReject},   {7'b0, e.rej});
            chk("changeValid",  e.id, {7'b0, changeValid},  {7'b0, e.cv});
            chk("changeAmount", e.id, {3'b0, changeAmount}, {3'b0, e.ca});
            chk("redLight",     e.id, {7'b0, redLight},     {7'b0, e.red});
        end
    end

    task automatic v(input logic m, input logic cvl, input logic [1:0] cc,
                     input logic b, input logic [4:0] p, input logic cn,
                     input logic cl, input logic ak,
                     input logic [4:0] ecr, input logic [6:0] eacc,
                     input logic ev, input logic erj, input logic ecv,
                     input logic [4:0] eca, input logic erd);
        @(negedge clk);
        mode      = m;
        coinValid = cvl;
        coinCode  = cc;
        buy       = b;
        price     = p;
        cancel    = cn;
        accClear  = cl;
        changeAck = ak;
        q.push_back('{n_id, ecr, eacc, ev, erj, ecv, eca, erd});
        n_id++;
    endtask

    task automatic rs();
        @(negedge clk);
        mode = 1'b0; coinValid = 1'b0; buy = 1'b0; cancel = 1'b0;
        accClear = 1'b0; changeAck = 1'b0; price = 5'd0;
        q.push_back('{n_id, 5'd0, 7'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0});
        n_id++;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        repeat (2) @(negedge clk);
        rs();
        // ack while no change pending is ignored
        v(1,0,0,0,0,0,0,1,       0,10'd0,0,0,0,0,0);
        // coins 5,5,2 then buy 10
        v(1,1,COIN_5,0,0,0,0,0,  5,0,0,0,0,0,0);
        v(1,1,COIN_5,0,0,0,0,0,  10,0,0,0,0,0,0);
        v(1,1,COIN_2,0,0,0,0,0,  12,0,0,0,0,0,0);
        v(1,0,0,1,10,0,0,0,      0,10,1,0,1,2,0);
        v(1,1,COIN_1,0,0,0,0,0,  0,10,0,1,1,2,0);
        v(1,0,0,0,0,0,0,1,       0,10,0,0,0,0,0);
        v(1,1,COIN_1,0,0,0,0,0,  1,10,0,0,0,0,0);
        // insufficient credit, then zero price
        v(1,1,COIN_2,0,0,0,0,0,  3,10,0,0,0,0,0);
        v(1,0,0,1,7,0,0,0,       3,10,0,0,0,0,1);
        v(1,1,COIN_5,0,0,0,0,0,  8,10,0,0,0,0,0);
        v(1,0,0,1,0,0,0,0,       8,10,0,0,0,0,1);
        v(1,0,0,0,0,1,0,0,       0,10,0,0,1,8,0);
        v(1,0,0,0,0,0,0,1,       0,10,0,0,0,0,0);
        // overflow reject and the exact-31 boundary
        v(1,1,COIN_10,0,0,0,0,0, 10,10,0,0,0,0,0);
        v(1,1,COIN_10,0,0,0,0,0, 20,10,0,0,0,0,0);
        v(1,1,COIN_5,0,0,0,0,0,  25,10,0,0,0,0,0);
        v(1,1,COIN_10,0,0,0,0,0, 25,10,0,1,0,0,0);
        v(1,1,COIN_5,0,0,0,0,0,  30,10,0,0,0,0,0);
        v(1,1,COIN_1,0,0,0,0,0,  31,10,0,0,0,0,0);
        v(1,1,COIN_1,0,0,0,0,0,  31,10,0,1,0,0,0);
        v(1,0,0,0,0,1,0,0,       0,10,0,0,1,31,0);
        v(1,0,0,0,0,0,0,1,       0,10,0,0,0,0,0);
        // coin and buy in the same cycle, exact price
        v(1,1,COIN_2,0,0,0,0,0,  2,10,0,0,0,0,0);
        v(1,1,COIN_2,0,0,0,0,0,  4,10,0,0,0,0,0);
        v(1,1,COIN_10,1,4,0,0,0, 0,14,1,1,0,0,0);
        v(1,0,0,0,0,1,0,0,       0,14,0,0,0,0,0);
        v(1,0,0,1,3,0,0,0,       0,14,0,0,0,0,0);
        // fill accumulator to 120 with exact sales
        for (int i = 0; i < 3; i++) begin
            v(1,1,COIN_10,0,0,0,0,0, 10,7'(14+31*i),0,0,0,0,0);
            v(1,1,COIN_10,0,0,0,0,0, 20,7'(14+31*i),0,0,0,0,0);
            v(1,1,COIN_10,0,0,0,0,0, 30,7'(14+31*i),0,0,0,0,0);
            v(1,1,COIN_1,0,0,0,0,0,  31,7'(14+31*i),0,0,0,0,0);
            v(1,0,0,1,31,0,0,0,      0,7'(45+31*i),1,0,0,0,0);
        end
        v(1,1,COIN_10,0,0,0,0,0, 10,107,0,0,0,0,0);
        v(1,1,COIN_2,0,0,0,0,0,  12,107,0,0,0,0,0);
        v(1,1,COIN_1,0,0,0,0,0,  13,107,0,0,0,0,0);
        v(1,0,0,1,13,0,0,0,      0,120,1,0,0,0,0);
        // saturating sale
        v(1,1,COIN_10,0,0,0,0,0, 10,120,0,0,0,0,0);
        v(1,1,COIN_2,0,0,0,0,0,  12,120,0,0,0,0,0);
        v(1,0,0,1,10,0,0,0,      0,127,1,0,1,2,1);
        v(1,0,0,0,0,0,0,1,       0,127,0,0,0,0,1);
        v(1,1,COIN_1,0,0,0,0,0,  1,127,0,0,0,0,1);
        v(1,0,0,0,0,0,1,0,       1,0,0,0,0,0,0);
        // clear coinciding with a sale
        v(1,1,COIN_5,0,0,0,0,0,  6,0,0,0,0,0,0);
        v(1,0,0,1,3,0,0,0,       0,3,1,0,1,3,0);
        v(1,0,0,0,0,0,0,1,       0,3,0,0,0,0,0);
        v(1,1,COIN_5,0,0,0,0,0,  5,3,0,0,0,0,0);
        v(1,0,0,1,4,0,1,0,       0,4,1,0,1,1,0);
        v(1,0,0,0,0,0,0,1,       0,4,0,0,0,0,0);
        // mode drop acts as cancel, owner-mode coin, reset in CHANGE
        v(1,1,COIN_5,0,0,0,0,0,  5,4,0,0,0,0,0);
        v(1,1,COIN_1,0,0,0,0,0,  6,4,0,0,0,0,0);
        v(0,0,0,0,0,0,0,0,       0,4,0,0,1,6,0);
        v(0,1,COIN_5,0,0,0,0,0,  0,4,0,1,1,6,0);
        rs();
        v(1,1,COIN_1,0,0,0,0,0,  1,0,0,0,0,0,0);
        v(1,0,0,0,0,0,0,0,       1,0,0,0,0,0,0);

        for (int k = 0; k < 20 && q.size() > 0; k++) @(negedge clk);
        if (q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: %0d left, want 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
